// File: rtl/scarf_pkg.sv
// Shared types and widths for the SCARF SPI front end and its byte bus.
package scarf_pkg;

    localparam int SCARF_ID_W   = 7;
    localparam int SCARF_BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        ID_BYTE,
        DATA_BYTE
    } scarf_fe_state_t;

    typedef struct packed {
        logic sclk_rise;
        logic sclk_fall;
        logic cs_fall;
        logic cs_rise;
    } scarf_edges_t;

endpackage

// File: rtl/scarf_sync.sv
// Multi-flop synchroniser for one asynchronous input, reset to a chosen level.
module scarf_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n_sync,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) sync_q <= {STAGES{RST_VAL}};
        else             sync_q <= sync_d;
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/scarf_spi_frontend.sv
// SPI mode-0 slave that turns an oversampled SPI stream into SCARF byte-bus strobes
// (byte0 = {rnw, slave_id}) and shifts the slaves' read data back out on miso.
module scarf_spi_frontend
    import scarf_pkg::*;
#(
    parameter int                    SYNC_STAGES = 2,
    parameter logic [SCARF_ID_W-1:0] IDLE_ID     = 7'h00
) (
    input  logic                    clk,
    input  logic                    rst_n_sync,
    input  logic                    spi_sclk,
    input  logic                    spi_cs_n,
    input  logic                    spi_mosi,
    output logic                    spi_miso,
    output logic                    spi_miso_oe,
    output logic [SCARF_BYTE_W-1:0] data_out,
    output logic                    data_out_valid,
    output logic                    data_out_finished,
    output logic [SCARF_ID_W-1:0]   slave_id,
    output logic                    rnw,
    input  logic [SCARF_BYTE_W-1:0] read_data_in
);

    // bit 0 = sclk, bit 1 = cs_n (idles high), bit 2 = mosi
    localparam logic [2:0] SYNC_RST = 3'b010;

    logic [2:0] sync_in;
    logic [2:0] sync_out;
    logic       sclk_s, cs_n_s, mosi_s;

    assign sync_in = {spi_mosi, spi_cs_n, spi_sclk};

    for (genvar i = 0; i < 3; i++) begin : g_sync
        scarf_sync #(
            .STAGES  (SYNC_STAGES),
            .RST_VAL (SYNC_RST[i])
        ) u_sync (
            .clk        (clk),
            .rst_n_sync (rst_n_sync),
            .d          (sync_in[i]),
            .q          (sync_out[i])
        );
    end

    assign sclk_s = sync_out[0];
    assign cs_n_s = sync_out[1];
    assign mosi_s = sync_out[2];

    scarf_fe_state_t           state_q, state_d;
    logic                      sclk_dly_q, cs_n_dly_q;
    logic [2:0]                bit_cnt_q, bit_cnt_d;
    logic [SCARF_BYTE_W-1:0]   rx_sr_q, rx_sr_d;
    logic [SCARF_BYTE_W-1:0]   tx_sr_q, tx_sr_d;
    logic                      reload_q, reload_d;
    logic [SCARF_BYTE_W-1:0]   data_out_q, data_out_d;
    logic                      valid_q, valid_d;
    logic                      finished_q, finished_d;
    logic                      fin_pend_q, fin_pend_d;
    logic [SCARF_ID_W-1:0]     slave_id_q, slave_id_d;
    logic                      rnw_q, rnw_d;

    scarf_edges_t              edges;
    logic                      active, rise_ok, fall_ok, byte_done, data_done;
    logic [SCARF_BYTE_W-1:0]   rx_next;

    always_comb begin
        edges.sclk_rise = sclk_s & ~sclk_dly_q;
        edges.sclk_fall = ~sclk_s & sclk_dly_q;
        edges.cs_fall   = ~cs_n_s & cs_n_dly_q;
        edges.cs_rise   = cs_n_s & ~cs_n_dly_q;
        // sclk is only honoured inside a transfer, so idle-bus toggling is dropped
        active    = (state_q != IDLE);
        rise_ok   = active & edges.sclk_rise;
        fall_ok   = active & edges.sclk_fall;
        byte_done = rise_ok & (bit_cnt_q == 3'd7);
        data_done = byte_done & (state_q == DATA_BYTE);
        rx_next   = {rx_sr_q[SCARF_BYTE_W-2:0], mosi_s};
    end

    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) state_q <= IDLE;
        else             state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (edges.cs_fall) state_d = ID_BYTE;
            ID_BYTE:   if (edges.cs_rise) state_d = IDLE;
                       else if (byte_done) state_d = DATA_BYTE;
            DATA_BYTE: if (edges.cs_rise) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        rx_sr_d    = rx_sr_q;
        tx_sr_d    = tx_sr_q;
        reload_d   = reload_q;
        data_out_d = data_out_q;
        slave_id_d = slave_id_q;
        rnw_d      = rnw_q;
        valid_d    = 1'b0;
        finished_d = fin_pend_q;
        fin_pend_d = 1'b0;

        if (rise_ok) begin
            rx_sr_d   = rx_next;
            bit_cnt_d = bit_cnt_q + 3'd1;
        end
        if (byte_done) begin
            reload_d = 1'b1;
            if (state_q == ID_BYTE) begin
                rnw_d      = rx_next[SCARF_BYTE_W-1];
                slave_id_d = rx_next[SCARF_ID_W-1:0];
            end else begin
                data_out_d = rx_next;
                valid_d    = 1'b1;
            end
        end
        // Slaves have half an sclk period after byte done to present read data.
        if (fall_ok) begin
            if (reload_q) begin
                tx_sr_d  = read_data_in;
                reload_d = 1'b0;
            end else begin
                tx_sr_d = {tx_sr_q[SCARF_BYTE_W-2:0], 1'b0};
            end
        end
        if (!active && edges.cs_fall) begin
            bit_cnt_d = '0;
            rx_sr_d   = '0;
            tx_sr_d   = '0;
            reload_d  = 1'b0;
        end
        if (active && edges.cs_rise) begin
            bit_cnt_d  = '0;
            rx_sr_d    = '0;
            tx_sr_d    = '0;
            reload_d   = 1'b0;
            slave_id_d = IDLE_ID;
            rnw_d      = 1'b0;
            // a byte finishing on the closing edge keeps valid and finished apart
            if (data_done) fin_pend_d = 1'b1;
            else           finished_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            sclk_dly_q <= 1'b0;
            cs_n_dly_q <= 1'b1;
            bit_cnt_q  <= '0;
            rx_sr_q    <= '0;
            tx_sr_q    <= '0;
            reload_q   <= 1'b0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            finished_q <= 1'b0;
            fin_pend_q <= 1'b0;
            slave_id_q <= IDLE_ID;
            rnw_q      <= 1'b0;
        end else begin
            sclk_dly_q <= sclk_s;
            cs_n_dly_q <= cs_n_s;
            bit_cnt_q  <= bit_cnt_d;
            rx_sr_q    <= rx_sr_d;
            tx_sr_q    <= tx_sr_d;
            reload_q   <= reload_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            finished_q <= finished_d;
            fin_pend_q <= fin_pend_d;
            slave_id_q <= slave_id_d;
            rnw_q      <= rnw_d;
        end
    end

    assign spi_miso_oe       = ~cs_n_s;
    assign spi_miso          = spi_miso_oe & tx_sr_q[SCARF_BYTE_W-1];
    assign data_out          = data_out_q;
    assign data_out_valid    = valid_q;
    assign data_out_finished = finished_q;
    assign slave_id          = slave_id_q;
    assign rnw               = rnw_q;

endmodule

// File: tb/tb_scarf_spi_frontend.sv
// Bench for scarf_spi_frontend: SPI master tasks, a small regmap slave model (id 0x01),
// and a scoreboard of expected data_out bytes.
module tb_scarf_spi_frontend;
    import scarf_pkg::*;

    localparam int HALF = 50;  // half sclk period = 5 clk, sclk = clk/10

    logic       clk = 1'b0;
    logic       rst_n_sync = 1'b0;
    logic       spi_sclk = 1'b0, spi_cs_n = 1'b1, spi_mosi = 1'b0;
    logic       spi_miso, spi_miso_oe;
    logic [7:0] data_out;
    logic       data_out_valid, data_out_finished;
    logic [6:0] slave_id;
    logic       rnw;
    logic [7:0] read_data_in;

    always #5 clk = ~clk;

    scarf_spi_frontend #(.SYNC_STAGES(2), .IDLE_ID(7'h00)) dut (
        .clk               (clk),
        .rst_n_sync        (rst_n_sync),
        .spi_sclk          (spi_sclk),
        .spi_cs_n          (spi_cs_n),
        .spi_mosi          (spi_mosi),
        .spi_miso          (spi_miso),
        .spi_miso_oe       (spi_miso_oe),
        .data_out          (data_out),
        .data_out_valid    (data_out_valid),
        .data_out_finished (data_out_finished),
        .slave_id          (slave_id),
        .rnw               (rnw),
        .read_data_in      (read_data_in)
    );

    int          errors = 0, checks = 0;
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Regmap slave model: first data byte is the address, later bytes auto-increment.
    // Addresses 2/3 hold read-only adc_data = 16'hA55A.
    logic [7:0] regs [0:7];
    logic [2:0] ptr;
    logic       ptr_vld;

    always @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            for (int i = 0; i < 8; i++) regs[i] <= 8'h00;
            regs[2] <= 8'hA5;
            regs[3] <= 8'h5A;
            ptr     <= '0;
            ptr_vld <= 1'b0;
        end else if (data_out_finished) begin
            ptr_vld <= 1'b0;
        end else if (data_out_valid && slave_id == 7'h01) begin
            if (!ptr_vld) begin
                ptr     <= data_out[2:0];
                ptr_vld <= 1'b1;
            end else begin
                if (!rnw && ptr != 3'd2 && ptr != 3'd3) regs[ptr] <= data_out;
                ptr <= ptr + 3'd1;
            end
        end
    end

    always_comb begin
        read_data_in = 8'h00;
        if (slave_id == 7'h01 && rnw) read_data_in = ptr_vld ? regs[ptr] : 8'h01;
    end

    // Scoreboard monitor
    logic [7:0]  exp_q [$];
    logic [7:0]  exp_b;
    int          valid_cnt = 0, fin_cnt = 0;
    int unsigned last_valid_cyc = 0, last_fin_cyc = 0;

    always @(negedge clk) begin
        if (rst_n_sync) begin
            if (data_out_valid) begin
                valid_cnt++;
                last_valid_cyc = cyc;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got data_out=%0h, expected no strobe", data_out);
                end else begin
                    exp_b = exp_q.pop_front();
                    check("data_out", 32'(data_out), 32'(exp_b));
                end
            end
            if (data_out_finished) begin
                fin_cnt++;
                last_fin_cyc = cyc;
                check("fin_id_idle", 32'({rnw, slave_id}), 32'h0);
                check("fin_not_with_valid", 32'(data_out_valid), 32'h0);
            end
        end
    end

    // SPI master
    logic [7:0] tx_buf [0:7];
    logic [7:0] rx_buf [0:7];
    logic [6:0] id_snap;
    logic       rnw_snap;

    task automatic spi_xfer(input int nbytes, input int extra_bits, input bit collide, input bit rst_mid);
        @(negedge clk);
        spi_cs_n = 1'b0;
        #HALF;
        for (int i = 0; i < nbytes; i++) begin
            for (int j = 7; j >= 0; j--) begin
                spi_mosi = tx_buf[i][j];
                #HALF;
                rx_buf[i][j] = spi_miso;
                spi_sclk = 1'b1;
                if (collide && i == nbytes - 1 && j == 0) spi_cs_n = 1'b1;
                #HALF;
                spi_sclk = 1'b0;
            end
        end
        for (int k = 0; k < extra_bits; k++) begin
            spi_mosi = tx_buf[nbytes][7-k];
            #HALF;
            spi_sclk = 1'b1;
            #HALF;
            spi_sclk = 1'b0;
        end
        if (rst_mid) begin
            rst_n_sync = 1'b0;
            spi_cs_n   = 1'b1;
        end else if (!collide) begin
            #HALF;
            id_snap  = slave_id;
            rnw_snap = rnw;
            spi_cs_n = 1'b1;
        end
        #(4*HALF);
    endtask

    typedef struct packed {
        logic [2:0]      n;
        logic [3:0][7:0] tx;
        logic [3:0][7:0] miso;
        logic [6:0]      id;
        logic            rd;
    } vec_t;

    vec_t vecs [5];

    function automatic vec_t mk(input logic [2:0] n, input logic [3:0][7:0] tx,
                                input logic [3:0][7:0] miso, input logic [6:0] id, input logic rd);
        vec_t v;
        v.n = n; v.tx = tx; v.miso = miso; v.id = id; v.rd = rd;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        int f0;
        for (int b = 0; b < int'(v.n); b++) tx_buf[b] = v.tx[b];
        for (int b = 1; b < int'(v.n); b++) exp_q.push_back(v.tx[b]);
        f0 = fin_cnt;
        spi_xfer(int'(v.n), 0, 1'b0, 1'b0);
        for (int b = 0; b < int'(v.n); b++)
            check({tag, "_miso"}, 32'(rx_buf[b]), 32'(v.miso[b]));
        check({tag, "_slave_id"}, 32'(id_snap), 32'(v.id));
        check({tag, "_rnw"}, 32'(rnw_snap), 32'(v.rd));
        check({tag, "_finished_once"}, 32'(fin_cnt - f0), 32'd1);
        check({tag, "_all_bytes_seen"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_idle_id_after"}, 32'(slave_id), 32'h00);
        check({tag, "_oe_low_between"}, 32'(spi_miso_oe), 32'h0);
    endtask

    initial begin
        int f0, v0;
        // {byte3,byte2,byte1,byte0}
        vecs[0] = mk(3'd3, {8'h00, 8'h01, 8'h00, 8'h01}, {8'h00, 8'h00, 8'h00, 8'h00}, 7'h01, 1'b0);
        vecs[1] = mk(3'd4, {8'h00, 8'h00, 8'h02, 8'h81}, {8'h5A, 8'hA5, 8'h01, 8'h00}, 7'h01, 1'b1);
        vecs[2] = mk(3'd3, {8'h00, 8'h00, 8'h00, 8'h85}, {8'h00, 8'h00, 8'h00, 8'h00}, 7'h05, 1'b1);
        vecs[3] = mk(3'd3, {8'h00, 8'h3C, 8'h05, 8'h01}, {8'h00, 8'h00, 8'h00, 8'h00}, 7'h01, 1'b0);
        vecs[4] = mk(3'd3, {8'h00, 8'h00, 8'h05, 8'h81}, {8'h00, 8'h3C, 8'h01, 8'h00}, 7'h01, 1'b1);

        repeat (3) @(negedge clk);
        check("rst_slave_id", 32'(slave_id), 32'h00);
        check("rst_outputs", 32'({rnw, data_out_valid, data_out_finished, spi_miso, spi_miso_oe}), 32'h0);
        check("rst_data_out", 32'(data_out), 32'h0);
        rst_n_sync = 1'b1;
        repeat (4) @(negedge clk);

        // Back-to-back transfers with a 2-sclk-period cs gap
        for (int v = 0; v < 5; v++) begin
            run_vec(vecs[v], $sformatf("vec%0d", v));
            if (v == 0) check("cfg_adc_enable", 32'(regs[0]), 32'h01);
            if (v == 2) check("wrong_id_no_change", 32'(regs[0]), 32'h01);
            if (v == 3) check("reg5_written", 32'(regs[5]), 32'h3C);
        end

        // Abort after 5 bits of byte2: the partial byte must not strobe
        tx_buf[0] = 8'h01; tx_buf[1] = 8'h00; tx_buf[2] = 8'hAA;
        exp_q.push_back(8'h00);
        f0 = fin_cnt; v0 = valid_cnt;
        spi_xfer(2, 5, 1'b0, 1'b0);
        check("abort_finished_once", 32'(fin_cnt - f0), 32'd1);
        check("abort_valid_count", 32'(valid_cnt - v0), 32'd1);
        check("abort_queue_empty", 32'(exp_q.size()), 32'd0);

        // Last sclk rise and cs rise land in the same cycle
        tx_buf[0] = 8'h01; tx_buf[1] = 8'h00; tx_buf[2] = 8'h07;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h07);
        f0 = fin_cnt;
        spi_xfer(3, 0, 1'b1, 1'b0);
        check("collide_finished_once", 32'(fin_cnt - f0), 32'd1);
        check("collide_fin_after_valid", 32'(last_fin_cyc - last_valid_cyc), 32'd1);
        check("collide_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of byte1
        tx_buf[0] = 8'h81; tx_buf[1] = 8'h02;
        f0 = fin_cnt; v0 = valid_cnt;
        spi_xfer(1, 3, 1'b0, 1'b1);
        check("midrst_slave_id", 32'(slave_id), 32'h00);
        check("midrst_outputs", 32'({rnw, data_out_valid, data_out_finished, spi_miso, spi_miso_oe}), 32'h0);
        rst_n_sync = 1'b1;
        repeat (10) @(negedge clk);
        check("midrst_no_finished", 32'(fin_cnt - f0), 32'd0);
        check("midrst_no_valid", 32'(valid_cnt - v0), 32'd0);
        run_vec(vecs[1], "post_rst_read");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
